// File: rtl/vortex_ctrl_csr_bank.sv
// Control/status register bank for NUM_CH Vortex channels: per-channel launch/run FSM with
// launch timeout, sticky DONE/ERR, run-cycle counter, interrupt, and a registered read path.
module vortex_ctrl_csr_bank #(
  parameter int          NUM_CH         = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          CYC_W          = 32,
  parameter int          LAUNCH_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] start,
  output logic              irq,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              ren,
  input  logic              wen,
  input  logic [3:0]        byte_en,
  output logic [31:0]       rdata,
  output logic              bus_busy
);

  localparam int                LCNT_W    = $clog2(LAUNCH_TIMEOUT);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LAUNCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_LAUNCH = 2'd1,
    CH_RUN    = 2'd2
  } ch_state_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_RDATA
  } bus_state_e;

  ch_state_e         state_q  [NUM_CH];
  ch_state_e         state_d  [NUM_CH];
  logic [CYC_W-1:0]  cycles_q [NUM_CH];
  logic [CYC_W-1:0]  cycles_d [NUM_CH];
  logic [LCNT_W-1:0] lcnt_q   [NUM_CH];
  logic [LCNT_W-1:0] lcnt_d   [NUM_CH];

  logic [NUM_CH-1:0] busy_q, done_q, err_q, irq_en_q;
  logic [NUM_CH-1:0] done_d, err_d, irq_en_d;
  logic [NUM_CH-1:0] done_set, err_set, launch_clr;
  logic [NUM_CH-1:0] ch_sel, start_wr, abort_wr, done_clr, err_clr, irq_en_wr;

  bus_state_e  bus_state_q, bus_state_d;
  logic        rd_capture;
  logic [31:0] rd_val;

  logic       in_window;
  logic [3:0] addr_ch;
  logic [1:0] addr_reg;
  logic       unused_ok;

  assign addr_ch   = addr[7:4];
  assign addr_reg  = addr[3:2];
  assign in_window = (addr[31:8] == BASE_ADDR[31:8]) && ({28'd0, addr_ch} < 32'(NUM_CH));
  assign unused_ok = ^{addr[1:0], wdata[31:9], wdata[7:4], byte_en[3:2]};

  // ABORT takes precedence over START when both bits arrive in one write.
  always_comb begin
    ch_sel    = '0;
    start_wr  = '0;
    abort_wr  = '0;
    done_clr  = '0;
    err_clr   = '0;
    irq_en_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i]    = wen && in_window && (addr_ch == 4'(i));
      start_wr[i]  = ch_sel[i] && (addr_reg == 2'd0) && byte_en[0] && wdata[0] && !wdata[1];
      abort_wr[i]  = ch_sel[i] && (addr_reg == 2'd0) && byte_en[0] && wdata[1];
      irq_en_wr[i] = ch_sel[i] && (addr_reg == 2'd0) && byte_en[1];
      done_clr[i]  = ch_sel[i] && (addr_reg == 2'd1) && byte_en[0] && wdata[2];
      err_clr[i]   = ch_sel[i] && (addr_reg == 2'd1) && byte_en[0] && wdata[3];
    end
  end

  always_comb begin
    done_set   = '0;
    err_set    = '0;
    launch_clr = '0;
    done_d     = done_q;
    err_d      = err_q;
    irq_en_d   = irq_en_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      cycles_d[i] = cycles_q[i];
      lcnt_d[i]   = lcnt_q[i];
      case (state_q[i])
        CH_IDLE: begin
          if (start_wr[i]) begin
            state_d[i]    = CH_LAUNCH;
            cycles_d[i]   = '0;
            lcnt_d[i]     = '0;
            launch_clr[i] = 1'b1;
          end
        end
        CH_LAUNCH: begin
          if (abort_wr[i]) begin
            state_d[i] = CH_IDLE;
            err_set[i] = 1'b1;
          end else if (busy_q[i]) begin
            state_d[i] = CH_RUN;
          end else if (lcnt_q[i] == LCNT_LAST) begin
            state_d[i] = CH_IDLE;
            err_set[i] = 1'b1;
          end else begin
            lcnt_d[i] = lcnt_q[i] + LCNT_W'(1);
          end
        end
        CH_RUN: begin
          if (cycles_q[i] != {CYC_W{1'b1}}) cycles_d[i] = cycles_q[i] + CYC_W'(1);
          if (abort_wr[i]) begin
            state_d[i] = CH_IDLE;
            err_set[i] = 1'b1;
          end else if (!busy_q[i]) begin
            state_d[i]  = CH_IDLE;
            done_set[i] = 1'b1;
          end
        end
        default: state_d[i] = CH_IDLE;
      endcase
      // A hardware set beats a software W1C landing on the same edge.
      if (done_set[i])                     done_d[i] = 1'b1;
      else if (launch_clr[i] || done_clr[i]) done_d[i] = 1'b0;
      if (err_set[i])                      err_d[i] = 1'b1;
      else if (launch_clr[i] || err_clr[i])  err_d[i] = 1'b0;
      if (irq_en_wr[i]) irq_en_d[i] = wdata[8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      done_q   <= '0;
      err_q    <= '0;
      irq_en_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= CH_IDLE;
        cycles_q[i] <= '0;
        lcnt_q[i]   <= '0;
      end
    end else begin
      busy_q   <= busy;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        cycles_q[i] <= cycles_d[i];
        lcnt_q[i]   <= lcnt_d[i];
      end
    end
  end

  always_comb begin
    start = '0;
    for (int i = 0; i < NUM_CH; i++) start[i] = (state_q[i] != CH_IDLE);
  end

  assign irq = |(irq_en_q & (done_q | err_q));

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_window && (addr_ch == 4'(i))) begin
        case (addr_reg)
          2'd0:    rd_val[8] = irq_en_q[i];
          2'd1:    rd_val[5:0] = {state_q[i], err_q[i], done_q[i], state_q[i] == CH_RUN, busy_q[i]};
          2'd2:    rd_val[CYC_W-1:0] = cycles_q[i];
          default: rd_val = '0;
        endcase
      end
    end
  end

  // A write always wins over a simultaneous read, so only a pure read stalls the bus.
  assign rd_capture = (bus_state_q == BUS_IDLE) && ren && !wen;
  assign bus_busy   = rd_capture;

  always_comb begin
    bus_state_d = BUS_IDLE;
    case (bus_state_q)
      BUS_IDLE:  bus_state_d = rd_capture ? BUS_RDATA : BUS_IDLE;
      BUS_RDATA: bus_state_d = BUS_IDLE;
      default:   bus_state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_state_q <= BUS_IDLE;
      rdata       <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      if (rd_capture) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_vortex_ctrl_csr_bank.sv
// Self-checking bench for vortex_ctrl_csr_bank: directed scenarios plus randomized launches
// checked against an outcome model derived from the launch/run timing rules.
module tb_vortex_ctrl_csr_bank;

  localparam int          NUM_CH = 4;
  localparam int          TO     = 8;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] BASE2  = 32'h9000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] start;
  logic              irq;
  logic [31:0]       addr, wdata, rdata;
  logic              ren, wen, bus_busy;
  logic [3:0]        byte_en;
  logic [0:0]        busy2, start2;
  logic              irq2, bus_busy2;
  logic [31:0]       rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  vortex_ctrl_csr_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .CYC_W(32), .LAUNCH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .busy(busy), .start(start), .irq(irq),
    .addr(addr), .wdata(wdata), .ren(ren), .wen(wen), .byte_en(byte_en),
    .rdata(rdata), .bus_busy(bus_busy)
  );

  vortex_ctrl_csr_bank #(.NUM_CH(1), .BASE_ADDR(BASE2), .CYC_W(4), .LAUNCH_TIMEOUT(TO)) dut_sat (
    .clk(clk), .reset(reset), .busy(busy2), .start(start2), .irq(irq2),
    .addr(addr), .wdata(wdata), .ren(ren), .wen(wen), .byte_en(byte_en),
    .rdata(rdata2), .bus_busy(bus_busy2)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byte_en = be; wen = 1'b1; ren = 1'b0;
    tick(1);
    wen = 1'b0; byte_en = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d2);
    addr = a; ren = 1'b1; wen = 1'b0;
    tick(1);
    d1 = rdata; d2 = rdata2; ren = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    logic [31:0] r1, r2;
    reset = 1'b1; busy = '0; busy2 = '0; ren = 0; wen = 0; addr = '0; wdata = '0; byte_en = '0;
    tick(2);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_start: got %h exp %h", start, 4'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b exp 0", irq); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h exp 0", rdata); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bus_busy: got %b exp 0", bus_busy); end
    reset = 1'b0;
    tick(1);
    bus_write(BASE, 32'h1, 4'h1);
    n_checks++; if (start !== 4'h1) begin n_fail++; $display("[TB] FAIL pre_reset_start: got %h exp 1", start); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL async_reset_start: got %h exp 0", start); end
    tick(1);
    reset = 1'b0;
    tick(1);
    addr = BASE + 32'h4; ren = 1'b1;
    #1;
    n_checks++; if (bus_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL read_wait_state: got %b exp 1", bus_busy); end
    @(posedge clk); #1;
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rdata_cycle_busy: got %b exp 0", bus_busy); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_status: got %h exp 0", rdata); end
    ren = 1'b0;
    bus_read(BASE, r1, r2);
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h exp 0", r1); end
  endtask

  task automatic test_normal_run;
    logic [31:0] r1, r2;
    bus_write(BASE + 32'h10, 32'h101, 4'hF);
    n_checks++; if (start !== 4'b0010) begin n_fail++; $display("[TB] FAIL run_start_rise: got %h exp 2", start); end
    tick(3);
    busy[1] = 1'b1;
    tick(20);
    busy[1] = 1'b0;
    tick(1);
    n_checks++; if (start !== 4'b0010) begin n_fail++; $display("[TB] FAIL run_start_hold: got %h exp 2", start); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL run_irq_early: got %b exp 0", irq); end
    tick(1);
    n_checks++; if (start !== 4'b0000) begin n_fail++; $display("[TB] FAIL run_start_fall: got %h exp 0", start); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL run_irq: got %b exp 1", irq); end
    bus_read(BASE + 32'h14, r1, r2);
    n_checks++; if (r1 !== 32'h4) begin n_fail++; $display("[TB] FAIL run_status: got %h exp 4", r1); end
    bus_read(BASE + 32'h18, r1, r2);
    n_checks++; if (r1 !== 32'd20) begin n_fail++; $display("[TB] FAIL run_cycles: got %0d exp 20", r1); end
    bus_write(BASE + 32'h14, 32'h4, 4'h1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL run_irq_clear: got %b exp 0", irq); end
    bus_write(BASE + 32'h10, 32'h0, 4'h2);
  endtask

  task automatic test_timeout;
    logic [31:0] r1, r2;
    bus_write(BASE, 32'h1, 4'h1);
    tick(TO - 1);
    n_checks++; if (start !== 4'h1) begin n_fail++; $display("[TB] FAIL timeout_early: got %h exp 1", start); end
    tick(1);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL timeout_start: got %h exp 0", start); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_irq: got %b exp 0", irq); end
    bus_read(BASE + 32'h4, r1, r2);
    n_checks++; if (r1 !== 32'h8) begin n_fail++; $display("[TB] FAIL timeout_status: got %h exp 8", r1); end
    bus_write(BASE + 32'h4, 32'h8, 4'h1);
    bus_read(BASE + 32'h4, r1, r2);
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL timeout_err_clear: got %h exp 0", r1); end
  endtask

  task automatic test_abort;
    logic [31:0] r1, r2;
    bus_write(BASE + 32'h20, 32'h3, 4'h1);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL abort_start_both: got %h exp 0", start); end
    bus_read(BASE + 32'h24, r1, r2);
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_both_status: got %h exp 0", r1); end
    bus_write(BASE + 32'h20, 32'h1, 4'h1);
    busy[2] = 1'b1;
    tick(3);
    bus_read(BASE + 32'h24, r1, r2);
    n_checks++; if (r1 !== 32'h23) begin n_fail++; $display("[TB] FAIL abort_run_status: got %h exp 23", r1); end
    bus_write(BASE + 32'h20, 32'h2, 4'h1);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL abort_start_fall: got %h exp 0", start); end
    bus_read(BASE + 32'h24, r1, r2);
    n_checks++; if (r1 !== 32'h9) begin n_fail++; $display("[TB] FAIL abort_status: got %h exp 9", r1); end
    busy[2] = 1'b0;
    tick(2);
    bus_write(BASE + 32'h24, 32'h8, 4'h1);
    bus_write(BASE + 32'h30, 32'h1, 4'h1);
    busy[3] = 1'b1;
    tick(5);
    busy[3] = 1'b0;
    tick(1);
    bus_write(BASE + 32'h34, 32'h4, 4'h1);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL w1c_race_start: got %h exp 0", start); end
    bus_read(BASE + 32'h34, r1, r2);
    n_checks++; if (r1 !== 32'h4) begin n_fail++; $display("[TB] FAIL w1c_race_done: got %h exp 4", r1); end
    bus_write(BASE + 32'h34, 32'h4, 4'h1);
    bus_read(BASE + 32'h34, r1, r2);
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL w1c_done_clear: got %h exp 0", r1); end
  endtask

  task automatic test_bus_corners;
    logic [31:0] r1, r2;
    bus_write(BASE, 32'h101, 4'b0010);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL lane1_no_launch: got %h exp 0", start); end
    bus_read(BASE, r1, r2);
    n_checks++; if (r1 !== 32'h100) begin n_fail++; $display("[TB] FAIL lane1_irq_en: got %h exp 100", r1); end
    bus_read(BASE + 32'hC, r1, r2);
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL reserved_read: got %h exp 0", r1); end
    bus_read(BASE, r1, r2);
    bus_read(BASE + 32'(16 * NUM_CH), r1, r2);
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL out_of_range_read: got %h exp 0", r1); end
    bus_write(BASE + 32'hC, 32'h1, 4'hF);
    bus_write(BASE + 32'(16 * NUM_CH), 32'h1, 4'hF);
    n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL bad_addr_write: got %h exp 0", start); end
    bus_write(BASE, 32'h0, 4'b0010);
    addr = BASE + 32'h10; wdata = 32'h100; byte_en = 4'b0010; wen = 1'b1; ren = 1'b1;
    #1;
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ren_wen_busy: got %b exp 0", bus_busy); end
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0; byte_en = 4'h0;
    tick(1);
    bus_read(BASE + 32'h10, r1, r2);
    n_checks++; if (r1 !== 32'h100) begin n_fail++; $display("[TB] FAIL ren_wen_write: got %h exp 100", r1); end
    bus_write(BASE + 32'h10, 32'h0, 4'b0010);
  endtask

  task automatic test_saturation;
    logic [31:0] r1, r2;
    bus_write(BASE2, 32'h1, 4'h1);
    n_checks++; if (start2 !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_start: got %b exp 1", start2); end
    busy2 = 1'b1;
    tick(30);
    busy2 = 1'b0;
    tick(2);
    n_checks++; if (start2 !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_start_fall: got %b exp 0", start2); end
    bus_read(BASE2 + 32'h8, r1, r2);
    n_checks++; if (r2 !== 32'd15) begin n_fail++; $display("[TB] FAIL sat_cycles: got %0d exp 15", r2); end
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("[TB] FAIL foreign_window: got %h exp 0", r1); end
  endtask

  // Outcome model: a launch reaches RUN only if busy arrives early enough for its registered
  // copy to be seen by the last launch-window edge; the run count equals the busy-high cycles.
  task automatic test_random;
    logic [31:0] r1, r2, exp_status, exp_cycles;
    logic [NUM_CH-1:0] exp_start;
    int ch, d, len;
    logic ie;
    for (int it = 0; it < 20; it++) begin
      ch  = $urandom_range(0, NUM_CH - 1);
      d   = (it < 4) ? ((it % 2 == 1) ? TO - 1 : TO - 2) : $urandom_range(0, TO + 1);
      len = $urandom_range(1, 25);
      ie  = 1'($urandom_range(0, 1));
      exp_status = (d <= TO - 2) ? 32'h4 : 32'h8;
      exp_cycles = (d <= TO - 2) ? 32'(len) : 32'h0;
      exp_start  = '0;
      exp_start[ch] = 1'b1;
      bus_write(BASE + 32'(16 * ch), {23'd0, ie, 7'd0, 1'b1}, 4'b0011);
      n_checks++; if (start !== exp_start) begin n_fail++; $display("[TB] FAIL rnd_start it%0d: got %h exp %h", it, start, exp_start); end
      tick(d);
      busy[ch] = 1'b1;
      tick(len);
      busy[ch] = 1'b0;
      tick(2);
      n_checks++; if (start !== 4'h0) begin n_fail++; $display("[TB] FAIL rnd_start_end it%0d: got %h exp 0", it, start); end
      n_checks++; if (irq !== ie) begin n_fail++; $display("[TB] FAIL rnd_irq it%0d: got %b exp %b", it, irq, ie); end
      bus_read(BASE + 32'(16 * ch) + 32'h4, r1, r2);
      n_checks++; if (r1 !== exp_status) begin n_fail++; $display("[TB] FAIL rnd_status it%0d: got %h exp %h", it, r1, exp_status); end
      bus_read(BASE + 32'(16 * ch) + 32'h8, r1, r2);
      n_checks++; if (r1 !== exp_cycles) begin n_fail++; $display("[TB] FAIL rnd_cycles it%0d: got %0d exp %0d", it, r1, exp_cycles); end
      bus_write(BASE + 32'(16 * ch) + 32'h4, 32'hC, 4'h1);
      bus_write(BASE + 32'(16 * ch), 32'h0, 4'b0010);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_irq_clear it%0d: got %b exp 0", it, irq); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_timeout();
    test_abort();
    test_bus_corners();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vortex_ctrl_csr_bank.md
# vortex_ctrl_csr_bank

Multi-channel control/status register bank between the AHB-side generic bus and NUM_CH Vortex instances. It supersedes the single-channel start/busy slave with the following additions:
- a per-channel launch state machine with launch timeout;
- sticky done/error flags and a run-cycle counter;
- an interrupt output;
- a one-wait-state registered read handshake.

## Interface
Parameters:
- NUM_CH, 4, number of Vortex channels (1..16)
- BASE_ADDR, 32'h8000_0000, byte address of channel 0 CTRL; must be 256-byte aligned
- CYC_W, 32, run-cycle counter width (1..32)
- LAUNCH_TIMEOUT, 1024, cycles allowed from launch to first sampled busy (>=2)

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- busy  in  NUM_CH  per-channel Vortex busy
- start  out  NUM_CH  per-channel Vortex run enable (level)
- irq  out  1  OR of all enabled channel interrupts
- addr  in  32  bus byte address (word-aligned)
- wdata  in  32  bus write data
- ren  in  1  bus read request
- wen  in  1  bus write request
- byte_en  in  4  write byte lanes
- rdata  out  32  bus read data
- bus_busy  out  1  bus wait (generic bus busy)

## Operation
- Channel ch window: BASE_ADDR + 16*ch. Registers at offsets:
  - 0x0 CTRL: bit0 START (W1, reads 0); bit1 ABORT (W1, reads 0); bit8 IRQ_EN (RW).
  - 0x4 STATUS: bit0 BUSY_Q (RO); bit1 RUNNING (RO); bit2 DONE (W1C); bit3 ERR (W1C); bits[5:4] state (RO).
  - 0x8 CYCLES: run-cycle count, zero-extended (RO).
  - 0xC: reserved, reads 0.
- Any address outside NUM_CH windows, or at a reserved offset, is a bad address:
  - writes are ignored;
  - reads return 32'h0 with the normal handshake.
- Byte lanes:
  - START/ABORT/DONE/ERR act only if byte_en[0];
  - IRQ_EN is written only if byte_en[1].
- busy[ch] is registered into BUSY_Q each cycle. All FSM decisions use BUSY_Q.
- Per-channel FSM states: IDLE=0, LAUNCH=1, RUN=2.
  - IDLE, START write: clear CYCLES, clear launch counter, clear DONE and ERR, go to LAUNCH.
  - LAUNCH:
    - BUSY_Q=1: go to RUN.
    - Else, if the launch counter reaches LAUNCH_TIMEOUT-1: set ERR, go to IDLE.
    - Else: increment the launch counter.
  - RUN:
    - CYCLES increments each cycle and saturates at all-ones.
    - BUSY_Q=0: set DONE, go to IDLE.
  - ABORT write in LAUNCH or RUN: go to IDLE and set ERR.
- START and ABORT in the same write: ABORT wins and START is ignored.
- START written in LAUNCH or RUN is ignored. ABORT written in IDLE is ignored.
- start[ch] = 1 while the state is LAUNCH or RUN. It is a registered output (decoded from state flops).
- RUNNING = (state==RUN).
- Hardware set of DONE/ERR in the same cycle as a W1C write to that bit: the set wins.
- irq = OR over ch of IRQ_EN & (DONE | ERR). Combinational from flops.
- Simultaneous ren and wen: the write is performed and the read is ignored (no wait state).

## Timing
- Reset values:
  - start=0, irq=0, rdata=0, bus_busy=0;
  - all states IDLE;
  - CYCLES, DONE, ERR, IRQ_EN, BUSY_Q and the launch counter all 0.
- Write: takes effect at the clock edge where wen=1 and bus_busy=0. Zero wait states; bus_busy stays 0.
- Read:
  - Bus FSM states are IDLE and RDATA.
  - In IDLE with ren=1 (wen=0): bus_busy=1 in that cycle, addr is captured, go to RDATA.
  - In RDATA: bus_busy=0, rdata holds the registered value sampled at the capture edge; return to IDLE.
  - ren in the RDATA cycle is a new request, handled next cycle.
- rdata holds its last value outside RDATA.
- start latency: a START write at edge N gives start=1 after edge N.
- busy[ch] rising before edge M → BUSY_Q=1 after M → RUN after M+1.
- start falls one edge after BUSY_Q falls. DONE and irq assert on that same edge.
- Timeout: with busy held 0, ERR sets and start falls LAUNCH_TIMEOUT edges after the START write edge.
- Reset asserted mid-operation: all flops clear immediately. start and irq drop without waiting for clk.

## Test plan
- Reset/idle: assert reset with start active → start=0 immediately. Read ch0 STATUS → 32'h0, with bus_busy=1 for exactly one cycle.
- Normal run, ch1:
  - stimulus: write 32'h101 to BASE+0x10 (IRQ_EN and START); drive busy[1] high 3 cycles later for 20 cycles;
  - response: start[1]=1 until one edge after BUSY_Q falls; STATUS DONE=1, state=0; CYCLES=20; irq=1;
  - then write 32'h4 to BASE+0x14 → irq=0.
- Timeout: LAUNCH_TIMEOUT=8, START ch0, busy held 0 → ERR=1 and start[0]=0 after 8 edges; irq stays 0 with IRQ_EN=0.
- Abort and precedence:
  - START+ABORT (32'h3) in IDLE → stays IDLE, ERR=0;
  - START, then ABORT during RUN → IDLE, ERR=1, start low next cycle;
  - W1C on DONE in the same cycle as busy falls → DONE reads 1.
- Bus corner cases:
  - write with byte_en=4'b0010 and wdata=32'h101 → IRQ_EN=1, no launch;
  - read BASE+0x0C and BASE+16*NUM_CH → 32'h0;
  - ren and wen together → write applied, bus_busy=0.
- Saturation: CYC_W=4, run for 30 cycles → CYCLES=15.
